// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: controller state encodings and
// the ceil-log2 helper also used by the SRAM model for its address width.
package fir_pkg;

   localparam logic [2:0] ST_CLEAR = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   function automatic int fir_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_delay_ctrl.sv
// Circular delay-line controller: writes each accepted sample into the SRAM ring,
// then streams the whole line back newest-to-oldest as indexed taps.
module fir_delay_ctrl
   import fir_pkg::*;
#(
   parameter int  SRAM_DEPTH = 10,
   parameter int  DATA_WIDTH = 16,
   localparam int ADDR_WIDTH = fir_clog2(SRAM_DEPTH)
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iInValid,
   input  logic [DATA_WIDTH-1:0] iInDt,
   output logic                  oInReady,
   input  logic                  iClr,
   output logic                  oCsn,
   output logic                  oWrn,
   output logic [ADDR_WIDTH-1:0] oAddr,
   output logic [DATA_WIDTH-1:0] oWrDt,
   input  logic [DATA_WIDTH-1:0] iRdDt,
   output logic                  oTapValid,
   output logic [DATA_WIDTH-1:0] oTapDt,
   output logic [ADDR_WIDTH-1:0] oTapIdx,
   output logic                  oTapLast,
   output logic                  oBusy
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(SRAM_DEPTH - 1);
   // Truncation is harmless: the true result is below SRAM_DEPTH <= 2^ADDR_WIDTH.
   localparam logic [ADDR_WIDTH-1:0] DEPTH_MOD = ADDR_WIDTH'(SRAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] sample_q, sample_d;
   logic                  tap_valid_q, tap_last_q;
   logic [ADDR_WIDTH-1:0] tap_idx_q;

   logic                  cnt_last_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;
   logic                  csn_s, wrn_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [DATA_WIDTH-1:0] wrdt_s;

   assign cnt_last_s = (cnt_q == LAST_IDX);

   always_comb begin
      if (cnt_q > wr_ptr_q) begin
         rd_addr_s = wr_ptr_q + DEPTH_MOD - cnt_q;
      end else begin
         rd_addr_s = wr_ptr_q - cnt_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      sample_d = sample_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_last_s) begin
               state_d = ST_IDLE;
               cnt_d   = ADDR_ZERO;
            end else begin
               cnt_d   = cnt_q + ADDR_ONE;
            end
         end
         ST_IDLE: begin
            if (iInValid) begin
               sample_d = iInDt;
               state_d  = ST_WRITE;
               cnt_d    = ADDR_ZERO;
            end else if (iClr) begin
               state_d  = ST_CLEAR;
               cnt_d    = ADDR_ZERO;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_d = ST_READ;
            cnt_d   = ADDR_ZERO;
         end
         ST_READ: begin
            if (cnt_last_s) begin
               state_d = ST_DRAIN;
               cnt_d   = ADDR_ZERO;
            end else begin
               cnt_d   = cnt_q + ADDR_ONE;
            end
         end
         ST_DRAIN: begin
            state_d  = ST_IDLE;
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? ADDR_ZERO : wr_ptr_q + ADDR_ONE;
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = ADDR_ZERO;
         end
      endcase
   end

   always_comb begin
      csn_s  = 1'b1;
      wrn_s  = 1'b1;
      addr_s = ADDR_ZERO;
      wrdt_s = DATA_ZERO;
      case (state_q)
         ST_CLEAR: begin
            csn_s  = 1'b0;
            wrn_s  = 1'b0;
            addr_s = cnt_q;
         end
         ST_WRITE: begin
            csn_s  = 1'b0;
            wrn_s  = 1'b0;
            addr_s = wr_ptr_q;
            wrdt_s = sample_q;
         end
         ST_READ: begin
            csn_s  = 1'b0;
            addr_s = rd_addr_s;
         end
         default: begin
            csn_s  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= ADDR_ZERO;
         wr_ptr_q    <= ADDR_ZERO;
         sample_q    <= DATA_ZERO;
         tap_valid_q <= 1'b0;
         tap_idx_q   <= ADDR_ZERO;
         tap_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         sample_q    <= sample_d;
         tap_valid_q <= (state_q == ST_READ);
         tap_idx_q   <= (state_q == ST_READ) ? cnt_q : ADDR_ZERO;
         tap_last_q  <= (state_q == ST_READ) && cnt_last_s;
      end
   end

   // Reset overrides every output combinationally so it takes effect in the same cycle.
   assign oCsn      = iRst | csn_s;
   assign oWrn      = iRst | wrn_s;
   assign oAddr     = iRst ? ADDR_ZERO : addr_s;
   assign oWrDt     = iRst ? DATA_ZERO : wrdt_s;
   assign oInReady  = ~iRst & (state_q == ST_IDLE);
   assign oBusy     = iRst | (state_q != ST_IDLE);
   assign oTapValid = ~iRst & tap_valid_q;
   assign oTapDt    = oTapValid ? iRdDt : DATA_ZERO;
   assign oTapIdx   = iRst ? ADDR_ZERO : tap_idx_q;
   assign oTapLast  = ~iRst & tap_last_q;

endmodule

// File: tb/tb_fir_delay_ctrl.sv
// Directed bench for fir_delay_ctrl (depth 4) paired with a registered-read SRAM model.
module tb_fir_delay_ctrl;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iInValid = 1'b0;
   logic [15:0] iInDt = 16'h0;
   logic        iClr = 1'b0;
   logic        oInReady, oCsn, oWrn, oTapValid, oTapLast, oBusy;
   logic [1:0]  oAddr, oTapIdx;
   logic [15:0] oWrDt, oTapDt, rd_q;
   logic [15:0] mem [0:3];

   int n_cmp = 0;
   int n_err = 0;

   fir_delay_ctrl #(.SRAM_DEPTH(4), .DATA_WIDTH(16)) dut (
      .iClk(iClk), .iRst(iRst), .iInValid(iInValid), .iInDt(iInDt),
      .oInReady(oInReady), .iClr(iClr), .oCsn(oCsn), .oWrn(oWrn),
      .oAddr(oAddr), .oWrDt(oWrDt), .iRdDt(rd_q), .oTapValid(oTapValid),
      .oTapDt(oTapDt), .oTapIdx(oTapIdx), .oTapLast(oTapLast), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   // SRAM model: synchronous write, read data registered one cycle after the command.
   always @(posedge iClk) begin
      if (iRst) begin
         rd_q <= 16'h0;
      end else if (!oCsn) begin
         if (!oWrn) mem[oAddr] <= oWrDt;
         else       rd_q <= mem[oAddr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller has just driven the first sweep cycle's inputs after a falling edge.
   task automatic clear_sweep();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge iClk);
         #1;
         check_eq("clr_csn", oCsn, 0);
         check_eq("clr_wrn", oWrn, 0);
         check_eq("clr_addr", oAddr, k);
         check_eq("clr_wrdt", oWrDt, 0);
         check_eq("clr_ready", oInReady, 0);
         check_eq("clr_busy", oBusy, 1);
      end
      @(negedge iClk); #1;
      check_eq("clr_done_ready", oInReady, 1);
      check_eq("clr_done_csn", oCsn, 1);
      check_eq("clr_done_busy", oBusy, 0);
   endtask

   // Called in an IDLE cycle; offers one sample and follows it to the next IDLE.
   task automatic run_sample(input logic [15:0] d, input logic [1:0] wa,
                             input logic [15:0] t0, input logic [15:0] t1,
                             input logic [15:0] t2, input logic [15:0] t3,
                             input int clr_at);
      logic [15:0] taps [4];
      logic [1:0]  ra;
      taps[0] = t0; taps[1] = t1; taps[2] = t2; taps[3] = t3;
      iInValid = 1'b1;
      iInDt    = d;
      iClr     = (clr_at == 0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge iClk);
         iInValid = 1'b0;
         iClr     = (c == clr_at);
         #1;
         if (c == 1) begin
            check_eq("wr_csn", oCsn, 0);
            check_eq("wr_wrn", oWrn, 0);
            check_eq("wr_addr", oAddr, wa);
            check_eq("wr_data", oWrDt, d);
            check_eq("wr_ready", oInReady, 0);
         end
         if (c >= 2 && c <= 5) begin
            ra = wa - 2'(c - 2);
            check_eq("rd_csn", oCsn, 0);
            check_eq("rd_wrn", oWrn, 1);
            check_eq("rd_addr", oAddr, ra);
         end
         if (c == 2) check_eq("tap_idle", oTapValid, 0);
         if (c >= 3 && c <= 6) begin
            check_eq("tap_valid", oTapValid, 1);
            check_eq("tap_idx", oTapIdx, c - 3);
            check_eq("tap_last", oTapLast, (c == 6));
            check_eq("tap_dt", oTapDt, taps[c-3]);
         end
         if (c == 6) begin
            check_eq("drain_csn", oCsn, 1);
            check_eq("drain_busy", oBusy, 1);
         end
         if (c == 7) begin
            check_eq("back_ready", oInReady, 1);
            check_eq("back_valid", oTapValid, 0);
            check_eq("back_busy", oBusy, 0);
            check_eq("back_csn", oCsn, 1);
         end
      end
      iClr = 1'b0;
   endtask

   initial begin
      int acc_n, tap_n, last_acc;
      logic acc_prev;
      logic [15:0] expq [$];

      for (int a = 0; a < 4; a++) mem[a] = 16'hDEAD;

      repeat (3) @(negedge iClk);
      #1;
      check_eq("rst_csn", oCsn, 1);
      check_eq("rst_wrn", oWrn, 1);
      check_eq("rst_addr", oAddr, 0);
      check_eq("rst_wrdt", oWrDt, 0);
      check_eq("rst_ready", oInReady, 0);
      check_eq("rst_tvalid", oTapValid, 0);
      check_eq("rst_tdt", oTapDt, 0);
      check_eq("rst_tidx", oTapIdx, 0);
      check_eq("rst_tlast", oTapLast, 0);
      check_eq("rst_busy", oBusy, 1);

      @(negedge iClk);
      iRst = 1'b0;
      clear_sweep();

      run_sample(16'h1234, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, -1);
      run_sample(16'h1, 2'd1, 16'h1, 16'h1234, 16'h0, 16'h0, -1);
      run_sample(16'h2, 2'd2, 16'h2, 16'h1, 16'h1234, 16'h0, -1);
      run_sample(16'h3, 2'd3, 16'h3, 16'h2, 16'h1, 16'h1234, -1);
      run_sample(16'h4, 2'd0, 16'h4, 16'h3, 16'h2, 16'h1, -1);
      run_sample(16'h5, 2'd1, 16'h5, 16'h4, 16'h3, 16'h2, -1);

      // Back-to-back offers: the sender advances its sample only after an accept.
      acc_n = 0; tap_n = 0; last_acc = 0; acc_prev = 1'b0;
      iInValid = 1'b1;
      iInDt    = 16'h21;
      for (int i = 0; i < 30; i++) begin
         if (i > 0) begin
            @(negedge iClk);
            if (acc_prev) begin
               iInDt = iInDt + 16'h1;
               if (acc_n == 3) iInValid = 1'b0;
            end
            #1;
         end
         acc_prev = 1'b0;
         if (oTapValid && oTapIdx == 2'd0) begin
            tap_n++;
            if (expq.size() > 0) check_eq("cont_tap0", oTapDt, expq.pop_front());
         end
         if (oInReady) check_eq("cont_idle_csn", oCsn, 1);
         if (oInReady && iInValid) begin
            if (acc_n > 0) check_eq("cont_gap", i - last_acc, 7);
            expq.push_back(iInDt);
            last_acc = i;
            acc_n++;
            acc_prev = 1'b1;
         end
      end
      check_eq("cont_acc_n", acc_n, 3);
      check_eq("cont_tap_n", tap_n, 3);

      run_sample(16'h7, 2'd1, 16'h7, 16'h23, 16'h22, 16'h21, -1);
      run_sample(16'h8, 2'd2, 16'h8, 16'h7, 16'h23, 16'h22, -1);

      iClr = 1'b1;
      @(negedge iClk);
      iClr = 1'b0;
      clear_sweep();

      run_sample(16'h9, 2'd3, 16'h9, 16'h0, 16'h0, 16'h0, -1);
      run_sample(16'hA, 2'd0, 16'hA, 16'h9, 16'h0, 16'h0, 3);
      run_sample(16'hB, 2'd1, 16'hB, 16'hA, 16'h9, 16'h0, 0);
      @(negedge iClk); #1;
      check_eq("clr_drop_ready", oInReady, 1);
      check_eq("clr_drop_csn", oCsn, 1);

      // Reset lands on the second READ cycle of sample 0xC.
      iInValid = 1'b1;
      iInDt    = 16'hC;
      @(negedge iClk);
      iInValid = 1'b0;
      #1;
      check_eq("mr_wr_addr", oAddr, 2);
      @(negedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      #1;
      check_eq("mr_tvalid", oTapValid, 0);
      check_eq("mr_tdt", oTapDt, 0);
      check_eq("mr_csn", oCsn, 1);
      check_eq("mr_wrn", oWrn, 1);
      check_eq("mr_addr", oAddr, 0);
      check_eq("mr_ready", oInReady, 0);
      check_eq("mr_busy", oBusy, 1);
      @(negedge iClk);
      @(negedge iClk);
      iRst = 1'b0;
      clear_sweep();
      run_sample(16'hD, 2'd0, 16'hD, 16'h0, 16'h0, 16'h0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
